tia_playfield_capture: RTL and testbench
========================================

# tia_playfield_capture

Receive-side counterpart of the playfield register cells: watches the serial playfield pixel stream produced during the visible part of a scanline and reconstructs the PF0/PF1/PF2 byte values that generated each half of the line. It sits beside the TIA core in the simulation and verification harness, and vcsmc tooling uses it to recover register state from rendered lines. It also flags when the right half does not reproduce the left half, which means a mid-line register write occurred.

## Interface
Parameters:
- PIXEL_CLOCKS, 4: color clocks per playfield bit (fixed TIA value; other values unsupported).
- LINE_BITS, 40: playfield bits per visible line (two halves of 20).

Ports:
- clk  in  1  color clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- line_start  in  1  one-cycle pulse on the first visible color clock of a line.
- pf_in  in  1  serial playfield pixel (OR of the three cells' outputs), one value per color clock.
- ref  in  1  CTRLPF reflect bit; sampled once per line (see Operation).
- out_ready  in  1  consumer accepts the output line this cycle.
- out_valid  out  1  captured line available; held until accepted.
- left_pf0, left_pf1, left_pf2  out  8 each  registers reconstructed from the left half.
- right_pf0, right_pf1, right_pf2  out  8 each  registers reconstructed from the right half, with reflection undone.
- mismatch  out  1  right-half registers differ from left-half registers; qualified by out_valid.
- overrun  out  1  sticky; a completed line was dropped because the buffer was full.

## Operation
- States: IDLE and CAPTURE.
- IDLE -> CAPTURE on line_start. Phase counter (0..3) and bit counter (0..39) clear to 0 that cycle.
- In CAPTURE:
  - Phase increments each clock and wraps 3 -> 0; bit increments when phase wraps.
  - pf_in is sampled when phase == 2 (mid-pixel).
- Bit mapping for half-index k (0..19):
  - k 0..3 -> pf0[4+k]
  - k 4..11 -> pf1[11-k], so k=4 -> pf1[7]
  - k 12..19 -> pf2[k-12]
- Left half: k = bit.
- Right half, line bit 20+j:
  - k = j when ref_l = 0; k = 19-j when ref_l = 1.
  - ref_l is ref sampled on the cycle bit reaches 20 at phase 0.
- pf0[3:0] is always 0 on both halves.
- After the sample of bit 39, the FSM returns to IDLE and the working registers transfer to the output buffer.
- line_start during CAPTURE aborts the current line: partial data is discarded and capture restarts from bit 0. No output is produced for the aborted line.
- Output buffer (one entry):
  - Transfer into the buffer when out_valid=0, or when out_valid=1 and out_ready=1 in the same cycle. The new line replaces the old one and out_valid stays 1.
  - If out_valid=1 and out_ready=0 at transfer time, the new line is dropped, overrun is set, and buffer contents are unchanged.
  - out_ready with out_valid=1 and no transfer that cycle -> out_valid clears next cycle.
- mismatch is computed from the working registers at transfer time and stored with the buffer.

## Timing
- Reset values:
  - state = IDLE; counters = 0.
  - out_valid, mismatch, overrun = 0.
  - All pf outputs = 8'h00.
  - rst mid-line abandons the line.
- With line_start at cycle t:
  - Bit n is sampled at t+4n+2.
  - The last sample is at t+158.
  - out_valid is first high at t+159; outputs are registered and stable from that cycle.
- Throughput: one line per 160 clocks minimum. A back-to-back line_start at t+159 is legal.
- overrun clears only on rst.

## Configuration
- TIA_PLAYFIELD_CAPTURE_MISMATCH_EN:
  - Defined: the 20-bit left/right comparator and the mismatch register are built.
  - Undefined: mismatch is tied to 0 and the comparator is omitted. All other behaviour is identical.

## Test plan
- Reset, then idle for 200 clocks -> out_valid=0, all outputs 0, overrun=0.
- Line with PF0=8'hA0, PF1=8'h5A, PF2=8'hC3, ref=0, out_ready=1 -> out_valid at t+159; left and right outputs equal those values; mismatch=0.
- Same registers with ref=1 (pixels of the right half reversed) -> right outputs equal left outputs; mismatch=0.
- Left half from PF1=8'hFF, right half from PF1=8'h00, other registers 0 -> left_pf1=8'hFF, right_pf1=8'h00, mismatch=1 (0 when the macro is undefined).
- Two lines back-to-back with out_ready=0 -> first line is retained, overrun=1 from the second line's transfer cycle; out_ready pulse clears out_valid one cycle later.
- line_start reissued at t+60, then rst asserted at a later line's bit 30 -> the aborted line produces no output; after rst, all outputs are 0 and state is IDLE.

Source files
------------

// File: rtl/tia_playfield_capture.sv
// tia_playfield_capture: rebuilds PF0/PF1/PF2 from one serial playfield line.
// Optional left/right comparator: TIA_PLAYFIELD_CAPTURE_MISMATCH_EN.
module tia_playfield_capture #(
  parameter int PIXEL_CLOCKS = 4,
  parameter int LINE_BITS    = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       line_start,
  input  logic       pf_in,
  input  logic       reflect,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] left_pf0,
  output logic [7:0] left_pf1,
  output logic [7:0] left_pf2,
  output logic [7:0] right_pf0,
  output logic [7:0] right_pf1,
  output logic [7:0] right_pf2,
  output logic       mismatch,
  output logic       overrun
);

  localparam int HALF = LINE_BITS / 2;
  localparam logic [1:0] PH_LAST = 2'(PIXEL_CLOCKS - 1);
  localparam logic [1:0] PH_MID  = 2'(PIXEL_CLOCKS / 2);
  localparam logic [5:0] BIT_LAST = 6'(LINE_BITS - 1);
  localparam logic [5:0] BIT_HALF = 6'(HALF);

  typedef enum logic {IDLE, CAPTURE} state_t;

  state_t      state;
  logic [1:0]  phase;
  logic [5:0]  bit_cnt;
  logic        ref_l;
  logic [19:0] left_k;
  logic [19:0] right_k;
  logic [19:0] left_nx;
  logic [19:0] right_nx;
  logic [4:0]  j;
  logic [4:0]  k_r;
  logic        sample;
  logic        xfer;
  logic        load;

  // Half-line bit k back into register form; pf0 low nibble never shown.
  function automatic logic [23:0] to_regs(input logic [19:0] v);
    logic [7:0] p0;
    logic [7:0] p1;
    logic [7:0] p2;
    p0 = {v[3:0], 4'h0};
    for (int i = 0; i < 8; i++) p1[7-i] = v[4+i];
    p2 = v[19:12];
    return {p0, p1, p2};
  endfunction

  always_comb begin
    sample   = (state == CAPTURE) && (phase == PH_MID) && !line_start;
    xfer     = sample && (bit_cnt == BIT_LAST);
    load     = xfer && (!out_valid || out_ready);
    j        = 5'(bit_cnt - BIT_HALF);
    k_r      = ref_l ? (5'(HALF - 1) - j) : j;
    left_nx  = left_k;
    right_nx = right_k;
    if (sample) begin
      if (bit_cnt < BIT_HALF) left_nx[bit_cnt[4:0]] = pf_in;
      else                    right_nx[k_r]         = pf_in;
    end
  end

  // The line_start cycle itself is phase 0, so the register resumes at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      phase   <= 2'd0;
      bit_cnt <= 6'd0;
      ref_l   <= 1'b0;
      left_k  <= 20'd0;
      right_k <= 20'd0;
    end else if (line_start) begin
      state   <= CAPTURE;
      phase   <= 2'd1;
      bit_cnt <= 6'd0;
      left_k  <= 20'd0;
      right_k <= 20'd0;
    end else if (state == CAPTURE) begin
      left_k  <= left_nx;
      right_k <= right_nx;
      if (phase == PH_LAST) begin
        phase   <= 2'd0;
        bit_cnt <= bit_cnt + 6'd1;
      end else begin
        phase <= phase + 2'd1;
      end
      if (phase == 2'd0 && bit_cnt == BIT_HALF) ref_l <= reflect;
      if (xfer) begin
        state   <= IDLE;
        phase   <= 2'd0;
        bit_cnt <= 6'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      {left_pf0, left_pf1, left_pf2}    <= 24'd0;
      {right_pf0, right_pf1, right_pf2} <= 24'd0;
    end else if (xfer) begin
      if (load) begin
        out_valid <= 1'b1;
        {left_pf0, left_pf1, left_pf2}    <= to_regs(left_nx);
        {right_pf0, right_pf1, right_pf2} <= to_regs(right_nx);
      end else begin
        overrun <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef TIA_PLAYFIELD_CAPTURE_MISMATCH_EN
  always_ff @(posedge clk) begin
    if (rst)       mismatch <= 1'b0;
    else if (load) mismatch <= (left_nx != right_nx);
  end
`else
  assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_tia_playfield_capture.sv
// Bench for tia_playfield_capture: table vectors, random lines, corner cases.
// Expected values come from a pixel-stream emitter and register masks.
module tb_tia_playfield_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic       line_start;
  logic       pf_in;
  logic       reflect;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] left_pf0, left_pf1, left_pf2;
  logic [7:0] right_pf0, right_pf1, right_pf2;
  logic       mismatch;
  logic       overrun;

  int checks = 0;
  int errors = 0;

`ifdef TIA_PLAYFIELD_CAPTURE_MISMATCH_EN
  localparam logic MM_EN = 1'b1;
`else
  localparam logic MM_EN = 1'b0;
`endif

  tia_playfield_capture dut (
    .clk(clk), .rst(rst), .line_start(line_start), .pf_in(pf_in),
    .reflect(reflect), .out_ready(out_ready), .out_valid(out_valid),
    .left_pf0(left_pf0), .left_pf1(left_pf1), .left_pf2(left_pf2),
    .right_pf0(right_pf0), .right_pf1(right_pf1), .right_pf2(right_pf2),
    .mismatch(mismatch), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] l0, l1, l2, r0, r1, r2;
    logic       rf;
    logic [23:0] e_left, e_right;
    logic        e_mm;
  } vec_t;

  // Pixel order of one half as the TIA emits it.
  function automatic logic [19:0] half_seq(input logic [7:0] p0, p1, p2);
    logic [19:0] s;
    int n;
    n = 0;
    for (int b = 4; b < 8; b++) begin s[n] = p0[b]; n++; end
    for (int b = 7; b >= 0; b--) begin s[n] = p1[b]; n++; end
    for (int b = 0; b < 8; b++) begin s[n] = p2[b]; n++; end
    return s;
  endfunction

  function automatic logic [39:0] pixels(input logic [7:0] l0, l1, l2,
                                         input logic [7:0] r0, r1, r2,
                                         input logic rf);
    logic [19:0] ls, rs;
    logic [39:0] p;
    ls = half_seq(l0, l1, l2);
    rs = half_seq(r0, r1, r2);
    for (int i = 0; i < 20; i++) begin
      p[i]    = ls[i];
      p[20+i] = rf ? rs[19-i] : rs[i];
    end
    return p;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk_line(input string nm, input vec_t v, input logic e_ov);
    chk({nm, " valid"}, 32'(out_valid), 32'd1);
    chk({nm, " left"}, 32'({left_pf0, left_pf1, left_pf2}), 32'(v.e_left));
    chk({nm, " right"}, 32'({right_pf0, right_pf1, right_pf2}),
        32'(v.e_right));
    chk({nm, " mismatch"}, 32'(mismatch), 32'(v.e_mm));
    chk({nm, " overrun"}, 32'(overrun), 32'(e_ov));
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " valid"}, 32'(out_valid), 32'd0);
    chk({nm, " left"}, 32'({left_pf0, left_pf1, left_pf2}), 32'd0);
    chk({nm, " right"}, 32'({right_pf0, right_pf1, right_pf2}), 32'd0);
    chk({nm, " mismatch"}, 32'(mismatch), 32'd0);
    chk({nm, " overrun"}, 32'(overrun), 32'd0);
  endtask

  // Starts at a negedge; after ncyc=159 it ends one cycle past the last sample.
  task automatic drive_line(input logic [39:0] pix, input logic rf,
                            input int ncyc, input bit chk_lat);
    for (int c = 0; c < ncyc; c++) begin
      if (chk_lat && c == 158) chk("latency", 32'(out_valid), 32'd0);
      line_start = (c == 0);
      pf_in      = pix[c/4];
      reflect    = rf;
      @(negedge clk);
    end
    line_start = 1'b0;
  endtask

  task automatic idle(input int n);
    line_start = 1'b0;
    for (int c = 0; c < n; c++) begin
      pf_in = 1'($urandom);
      @(negedge clk);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] l0, l1, l2, r0, r1, r2,
                              input logic rf);
    vec_t v;
    v.l0 = l0; v.l1 = l1; v.l2 = l2;
    v.r0 = r0; v.r1 = r1; v.r2 = r2;
    v.rf = rf;
    v.e_left  = {l0 & 8'hF0, l1, l2};
    v.e_right = {r0 & 8'hF0, r1, r2};
    v.e_mm    = MM_EN && (v.e_left != v.e_right);
    return v;
  endfunction

  task automatic run_vec(input string nm, input vec_t v, input logic e_ov);
    drive_line(pixels(v.l0, v.l1, v.l2, v.r0, v.r1, v.r2, v.rf), v.rf,
               159, 1'b1);
    chk_line(nm, v, e_ov);
  endtask

  vec_t vecs[5];
  vec_t va, vb, vc, vr;

  initial begin
    vecs[0] = '{8'hA0, 8'h5A, 8'hC3, 8'hA0, 8'h5A, 8'hC3, 1'b0,
                24'hA05AC3, 24'hA05AC3, 1'b0};
    vecs[1] = '{8'hA0, 8'h5A, 8'hC3, 8'hA0, 8'h5A, 8'hC3, 1'b1,
                24'hA05AC3, 24'hA05AC3, 1'b0};
    vecs[2] = '{8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0,
                24'h00FF00, 24'h000000, MM_EN};
    vecs[3] = '{8'hFF, 8'h00, 8'h81, 8'hFF, 8'h00, 8'h81, 1'b1,
                24'hF00081, 24'hF00081, 1'b0};
    vecs[4] = '{8'h3F, 8'h00, 8'h01, 8'h30, 8'h00, 8'h80, 1'b1,
                24'h300001, 24'h300080, MM_EN};

    rst = 1'b1; line_start = 1'b0; pf_in = 1'b0;
    reflect = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(200);
    chk_zero("reset_idle");

    for (int i = 0; i < 5; i++) run_vec($sformatf("vec%0d", i), vecs[i], 1'b0);

    for (int i = 0; i < 10; i++) begin
      logic [7:0] a0, a1, a2;
      a0 = 8'($urandom); a1 = 8'($urandom); a2 = 8'($urandom);
      if ($urandom_range(0, 1) == 0)
        vr = mk(a0, a1, a2, a0, a1, a2, 1'($urandom));
      else
        vr = mk(a0, a1, a2, 8'($urandom), 8'($urandom), 8'($urandom),
                1'($urandom));
      run_vec($sformatf("rand%0d", i), vr, 1'b0);
    end
    @(negedge clk);
    chk("accept_clear", 32'(out_valid), 32'd0);

    out_ready = 1'b0;
    va = mk(8'h50, 8'h3C, 8'h96, 8'h50, 8'h3C, 8'h96, 1'b0);
    vb = mk(8'hF0, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b1);
    run_vec("b2b_first", va, 1'b0);
    drive_line(pixels(vb.l0, vb.l1, vb.l2, vb.r0, vb.r1, vb.r2, vb.rf),
               vb.rf, 159, 1'b0);
    chk_line("b2b_kept", va, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("b2b_pop_valid", 32'(out_valid), 32'd0);
    chk("b2b_sticky", 32'(overrun), 32'd1);

    drive_line(40'($urandom) ^ {8'($urandom), 32'd0}, 1'b0, 60, 1'b0);
    vc = mk(8'h90, 8'h81, 8'h18, 8'h90, 8'h81, 8'h18, 1'b1);
    run_vec("abort", vc, 1'b1);

    drive_line(40'hFF_FFFF_FFFF, 1'b0, 122, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_zero("midline_rst");
    idle(200);
    chk("rst_idle_valid", 32'(out_valid), 32'd0);

    run_vec("post_rst", mk(8'hC0, 8'h12, 8'h34, 8'hC0, 8'h12, 8'h34, 1'b0),
            1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
